// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
// Bus-master front end: turns single CPU read/write requests into one
// arbitrated, address-strobed bus access, with slave-ready timeout and abort
// on grant loss.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   cpu_req/rw/addr/wr_data : CPU request, held until cpu_stall is low
//   cpu_rd_data, cpu_err    : access result, valid in DONE, held afterwards
//   cpu_stall               : CPU must hold its request/pipeline
//   bus_req / bus_grant     : request to / grant from the bus arbiter
//   bus_as                  : address strobe, one cycle per access
//   bus_rw/addr/wr_data     : registered access attributes
//   bus_rd_data, bus_rdy    : slave read data and ready
// ---------------------------------------------------------------------------
module bus_master_if #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_err,
    output logic              cpu_stall,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              bus_as,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             cnt_expired;

    // The last permitted WAIT cycle; >= keeps the counter from ever wrapping.
    assign cnt_expired = (wait_cnt >= CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; grant loss outranks slave ready, ready outranks timeout
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_grant) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nxt = bus_grant ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                if (!bus_grant || bus_rdy || cnt_expired) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        bus_req   = 1'b0;
        bus_as    = 1'b0;
        cpu_stall = 1'b0;
        unique case (state)
            S_IDLE: begin
                cpu_stall = cpu_req;
            end
            S_REQ: begin
                bus_req   = 1'b1;
                cpu_stall = 1'b1;
            end
            S_ACCESS: begin
                bus_req   = 1'b1;
                bus_as    = 1'b1;
                cpu_stall = 1'b1;
            end
            S_WAIT: begin
                bus_req   = 1'b1;
                cpu_stall = 1'b1;
            end
            default: begin
                bus_req   = 1'b0;
            end
        endcase
    end

    // Access attributes, result registers and WAIT-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rw      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            cpu_rd_data <= '0;
            cpu_err     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        bus_rw      <= cpu_rw;
                        bus_addr    <= cpu_addr;
                        bus_wr_data <= cpu_wr_data;
                        cpu_err     <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    wait_cnt <= '0;
                    if (!bus_grant) begin
                        cpu_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!bus_grant) begin
                        // Grant lost: flag error, previous read data is kept.
                        cpu_err <= 1'b1;
                    end else if (bus_rdy) begin
                        cpu_rd_data <= bus_rw ? '0 : bus_rd_data;
                    end else if (cnt_expired) begin
                        cpu_err     <= 1'b1;
                        cpu_rd_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    wait_cnt <= wait_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// ---------------------------------------------------------------------------
// tb_bus_master_if
// Self-checking bench for bus_master_if (TIMEOUT = 4). Each transaction is
// described by its CPU request, the grant delay, the slave ready delay and an
// optional grant-drop cycle; the expected DONE cycle and result come from a
// hand-written table or from a timing model built on cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_bus_master_if;

    localparam int unsigned AW   = 30;
    localparam int unsigned DW   = 32;
    localparam int unsigned TMO  = 4;
    localparam int          NONE = 1000;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] sdata;
        int            gdly;   // grant first seen in cycle 1+gdly
        int            rdly;   // rdy in WAIT cycle index rdly (0 = first)
        int            drop;   // grant low from this cycle on (NONE = never)
        int            done;   // expected DONE cycle
        logic          err;
        logic [DW-1:0] rd;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wr_data;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_err;
    logic          cpu_stall;
    logic          bus_req;
    logic          bus_grant;
    logic          bus_as;
    logic          bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data;
    logic          bus_rdy;

    int n_pass;
    int n_chk;
    logic [DW-1:0] model_rd;

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_as(bus_as),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected outcome from the transaction's timing parameters.
    function automatic vec_t model(input vec_t v, input logic [DW-1:0] prev_rd);
        vec_t r = v;
        int a = 2 + v.gdly;
        int dk, ek;
        if (v.drop == a) begin
            r.done = a + 1;
            r.err  = 1'b1;
            r.rd   = prev_rd;
        end else begin
            dk = (v.drop > a) ? v.drop - (a + 1) : NONE;
            ek = int'(TMO) - 1;
            if (v.rdly < ek) ek = v.rdly;
            if (dk < ek) ek = dk;
            r.done = a + 2 + ek;
            if (dk == ek) begin
                r.err = 1'b1;
                r.rd  = prev_rd;
            end else if (v.rdly == ek) begin
                r.err = 1'b0;
                r.rd  = v.rw ? '0 : v.sdata;
            end else begin
                r.err = 1'b1;
                r.rd  = '0;
            end
        end
        return r;
    endfunction

    // CPU, arbiter and slave behaviour for cycle c of a transaction.
    task automatic drive_cycle(input vec_t v, input int c);
        int a = 2 + v.gdly;
        rst         = 1'b0;
        cpu_req     = (c < v.done);
        cpu_rw      = v.rw;
        cpu_addr    = v.addr;
        cpu_wr_data = v.wdata;
        bus_grant   = (c >= 1 + v.gdly) && (c < v.drop) && (c < v.done);
        bus_rdy     = (c == a + 1 + v.rdly) && (c < v.done);
        bus_rd_data = v.sdata;
    endtask

    // Runs one transaction plus one idle cycle; cycle 0 may already be driven.
    task automatic run_txn(input vec_t v, input bit started, input string tag);
        int a = 2 + v.gdly;
        for (int c = 0; c <= v.done + 1; c++) begin
            if (!(c == 0 && started)) begin
                @(posedge clk);
                #1;
                drive_cycle(v, c);
                @(negedge clk);
            end
            chk($sformatf("%s stall@%0d", tag, c), 64'(cpu_stall), 64'(c < v.done));
            chk($sformatf("%s req@%0d", tag, c), 64'(bus_req), 64'(c >= 1 && c < v.done));
            chk($sformatf("%s as@%0d", tag, c), 64'(bus_as), 64'(c == a));
            if (c >= 1) begin
                chk($sformatf("%s rw@%0d", tag, c), 64'(bus_rw), 64'(v.rw));
                chk($sformatf("%s addr@%0d", tag, c), 64'(bus_addr), 64'(v.addr));
                chk($sformatf("%s wdata@%0d", tag, c), 64'(bus_wr_data), 64'(v.wdata));
            end
            if (c >= v.done) begin
                chk($sformatf("%s err@%0d", tag, c), 64'(cpu_err), 64'(v.err));
                chk($sformatf("%s rd@%0d", tag, c), 64'(cpu_rd_data), 64'(v.rd));
            end
        end
        model_rd = v.rd;
    endtask

    function automatic vec_t mk(input logic rw, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] sdata,
                                input int g, input int r, input int drop, input int done,
                                input logic err, input logic [DW-1:0] rd);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wdata = wdata; v.sdata = sdata;
        v.gdly = g; v.rdly = r; v.drop = drop; v.done = done;
        v.err = err; v.rd = rd;
        return v;
    endfunction

    vec_t tbl [9];
    vec_t v;
    vec_t rs;
    vec_t fresh;

    initial begin
        n_pass = 0;
        n_chk  = 0;
        model_rd = '0;

        //          rw    addr           wdata          sdata          g   r   drop  done err   rd
        tbl[0] = mk(1'b0, 30'h100,      32'h0,         32'hDEADBEEF,  1,  0,  NONE, 5,  1'b0, 32'hDEADBEEF);
        tbl[1] = mk(1'b1, 30'h3FF,      32'h12345678,  32'hFFFFFFFF,  1,  3,  NONE, 8,  1'b0, 32'h0);
        tbl[2] = mk(1'b0, 30'h2A,       32'h0,         32'hCAFEF00D,  10, 1,  NONE, 15, 1'b0, 32'hCAFEF00D);
        tbl[3] = mk(1'b0, 30'h55,       32'h0,         32'h11111111,  1,  99, NONE, 8,  1'b1, 32'h0);
        tbl[4] = mk(1'b0, 30'h88,       32'h0,         32'hA5A5A5A5,  2,  0,  NONE, 6,  1'b0, 32'hA5A5A5A5);
        tbl[5] = mk(1'b0, 30'h99,       32'h0,         32'h22222222,  1,  2,  5,    6,  1'b1, 32'hA5A5A5A5);
        tbl[6] = mk(1'b0, 30'h9A,       32'h0,         32'h33333333,  1,  1,  5,    6,  1'b1, 32'hA5A5A5A5);
        tbl[7] = mk(1'b1, 30'hAA,       32'h0BADC0DE,  32'h44444444,  1,  0,  3,    4,  1'b1, 32'hA5A5A5A5);
        tbl[8] = mk(1'b1, 30'h3FFFFFFF, 32'hFFFFFFFF,  32'h55555555,  3,  1,  NONE, 8,  1'b0, 32'h0);

        // Reset and reset values
        rst = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        bus_grant = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst bus_req", 64'(bus_req), 64'd0);
        chk("rst bus_as", 64'(bus_as), 64'd0);
        chk("rst bus_rw", 64'(bus_rw), 64'd0);
        chk("rst bus_addr", 64'(bus_addr), 64'd0);
        chk("rst bus_wr_data", 64'(bus_wr_data), 64'd0);
        chk("rst cpu_rd_data", 64'(cpu_rd_data), 64'd0);
        chk("rst cpu_err", 64'(cpu_err), 64'd0);
        chk("rst cpu_stall", 64'(cpu_stall), 64'd0);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i], 1'b0, $sformatf("tbl%0d", i));
        end

        // Random transactions against the timing model
        for (int i = 0; i < 40; i++) begin
            v.rw    = 1'($urandom_range(0, 1));
            v.addr  = AW'($urandom);
            v.wdata = $urandom;
            v.sdata = $urandom;
            v.gdly  = int'($urandom_range(1, 4));
            v.rdly  = int'($urandom_range(0, 5));
            v.drop  = ($urandom_range(0, 5) == 0) ? 2 + v.gdly + int'($urandom_range(0, 3)) : NONE;
            v = model(v, model_rd);
            run_txn(v, 1'b0, $sformatf("rnd%0d", i));
        end

        // Reset in WAIT, request held, fresh access afterwards
        run_txn(tbl[0], 1'b0, "pre");
        rs = mk(1'b0, 30'h123, 32'h0, 32'h77777777, 1, 99, NONE, NONE, 1'b0, 32'h0);
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk);
            #1;
            drive_cycle(rs, c);
            if (c == 4) rst = 1'b1;
            @(negedge clk);
        end
        chk("rstw req before", 64'(bus_req), 64'd1);
        fresh = mk(1'b1, 30'h2468, 32'h13579BDF, 32'h66666666, 1, 1, NONE, 0, 1'b0, 32'h0);
        fresh = model(fresh, 32'h0);
        @(posedge clk);
        #1;
        drive_cycle(fresh, 0);
        @(negedge clk);
        chk("rstw bus_req", 64'(bus_req), 64'd0);
        chk("rstw bus_as", 64'(bus_as), 64'd0);
        chk("rstw bus_rw", 64'(bus_rw), 64'd0);
        chk("rstw bus_addr", 64'(bus_addr), 64'd0);
        chk("rstw bus_wr_data", 64'(bus_wr_data), 64'd0);
        chk("rstw cpu_rd_data", 64'(cpu_rd_data), 64'd0);
        chk("rstw cpu_err", 64'(cpu_err), 64'd0);
        run_txn(fresh, 1'b1, "fresh");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
